uart_trx_param: RTL and testbench



---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tick_gen.sv | 31 +++
 rtl/uart_trx_param.sv | 267 ++++++++++++++++++++++++++
 tb/tb_uart_trx_param.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: FSM state encodings, idle line level
// and a constant-width helper.
package uart_pkg;

    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic [2:0] RX_IDLE      = 3'd0;
    localparam logic [2:0] RX_START     = 3'd1;
    localparam logic [2:0] RX_DATA      = 3'd2;
    localparam logic [2:0] RX_PARITY    = 3'd3;
    localparam logic [2:0] RX_STOP      = 3'd4;
    localparam logic [2:0] RX_WAIT_HIGH = 3'd5;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// BAUD_DIV prescaler: one-cycle tick every BAUD_DIV clocks, restarted by a synchronous clear.
module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = clog2(BAUD_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CW'(BAUD_DIV - 1));

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tick_o) cnt_d = '0;
    end

    // NOTE: sequential state is written with non-blocking (<=) assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_trx_param.sv
// Parametrised full-duplex UART: valid/ready byte side, oversampled RX with false-start,
// framing and overrun detection. Define UART_PARITY_EN to add a parity bit to every frame.
module uart_trx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_DIV   = 27,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);

    localparam int TW = clog2(OVERSAMPLE);
    localparam int BW = clog2(DATA_BITS);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);

    // ------------------------------------------------------------------ TX
    logic [2:0]           tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [TW-1:0]        tx_tcnt_q, tx_tcnt_d;
    logic [BW-1:0]        tx_bcnt_q, tx_bcnt_d;
    logic                 tx_par_q, tx_par_d;
    logic                 txd_q, txd_d;
    logic                 tx_tick, tx_accept, tx_bit_end;

    assign tx_ready   = (tx_state_q == TX_IDLE);
    assign tx_accept  = tx_valid && tx_ready;
    assign tx_bit_end = tx_tick && (tx_tcnt_q == T_LAST);
    assign txd        = txd_q;

    uart_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_tx_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (tx_accept),
        .tick_o (tx_tick)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bcnt_d  = tx_bcnt_q;
        tx_par_d   = tx_par_q;
        if (tx_state_q != TX_IDLE && tx_tick) tx_tcnt_d = tx_bit_end ? '0 : tx_tcnt_q + 1'b1;
        case (tx_state_q)
            TX_IDLE: if (tx_accept) begin
                tx_state_d = TX_START;
                tx_shift_d = tx_data;
                tx_tcnt_d  = '0;
                tx_bcnt_d  = '0;
                tx_par_d   = (^tx_data) ^ PARITY_ODD;
            end
            TX_START: if (tx_bit_end) tx_state_d = TX_DATA;
            TX_DATA: if (tx_bit_end) begin
                tx_shift_d = tx_shift_q >> 1;
                if (tx_bcnt_q == B_LAST) begin
                    tx_bcnt_d = '0;
`ifdef UART_PARITY_EN
                    tx_state_d = TX_PARITY;
`else
                    tx_state_d = TX_STOP;
`endif
                end else begin
                    tx_bcnt_d = tx_bcnt_q + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: if (tx_bit_end) tx_state_d = TX_STOP;
`endif
            TX_STOP: if (tx_bit_end) begin
                if (tx_bcnt_q == S_LAST) tx_state_d = TX_IDLE;
                else                     tx_bcnt_d  = tx_bcnt_q + 1'b1;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // txd is registered from the next state so the line never glitches between bits.
    always_comb begin
        case (tx_state_d)
            TX_START:  txd_d = ~IDLE_LEVEL;
            TX_DATA:   txd_d = tx_shift_d[0];
            TX_PARITY: txd_d = tx_par_d;
            default:   txd_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_tcnt_q  <= '0;
            tx_bcnt_q  <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= IDLE_LEVEL;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bcnt_q  <= tx_bcnt_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
        end
    end

    // ------------------------------------------------------------------ RX
    logic                 rx_sync1_q, rx_sync2_q, rx_s;
    logic [2:0]           rx_state_q, rx_state_d;
    logic [TW-1:0]        rx_tcnt_q, rx_tcnt_d;
    logic [BW-1:0]        rx_bcnt_q, rx_bcnt_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_done_q, rx_done_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_tick, rx_mid_start, rx_mid_bit;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q, rx_frame_err_q, rx_parity_err_q, rx_overrun_q;
`ifdef UART_PARITY_EN
    logic                 rx_perr_q, rx_perr_d;
`else
    logic                 rx_perr_q;
    assign rx_perr_q = 1'b0;
`endif

    assign rx_s         = rx_sync2_q;
    assign rx_mid_start = rx_tick && (rx_tcnt_q == T_HALF);
    assign rx_mid_bit   = rx_tick && (rx_tcnt_q == T_LAST);

    uart_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_rx_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (1'b0),
        .tick_o (rx_tick)
    );

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tick ? rx_tcnt_q + 1'b1 : rx_tcnt_q;
        rx_bcnt_d  = rx_bcnt_q;
        rx_shift_d = rx_shift_q;
        rx_ferr_d  = rx_ferr_q;
        rx_done_d  = 1'b0;
`ifdef UART_PARITY_EN
        rx_perr_d  = rx_perr_q;
`endif
        case (rx_state_q)
            RX_IDLE: begin
                rx_tcnt_d = '0;
                if (!rx_s) rx_state_d = RX_START;
            end
            RX_START: if (rx_mid_start) begin
                rx_tcnt_d  = '0;
                rx_bcnt_d  = '0;
                rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_mid_bit) begin
                rx_tcnt_d  = '0;
                rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                if (rx_bcnt_q == B_LAST) begin
                    rx_bcnt_d = '0;
`ifdef UART_PARITY_EN
                    rx_state_d = RX_PARITY;
`else
                    rx_state_d = RX_STOP;
`endif
                end else begin
                    rx_bcnt_d = rx_bcnt_q + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: if (rx_mid_bit) begin
                rx_tcnt_d  = '0;
                rx_perr_d  = rx_s ^ (^rx_shift_q) ^ PARITY_ODD;
                rx_state_d = RX_STOP;
            end
`endif
            // A low stop bit may be a break; hold off new frames until the line recovers.
            RX_STOP: if (rx_mid_bit) begin
                rx_tcnt_d  = '0;
                rx_done_d  = 1'b1;
                rx_ferr_d  = ~rx_s;
                rx_state_d = rx_s ? RX_IDLE : RX_WAIT_HIGH;
            end
            RX_WAIT_HIGH: if (rx_s) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync1_q <= IDLE_LEVEL;
            rx_sync2_q <= IDLE_LEVEL;
            rx_state_q <= RX_IDLE;
            rx_tcnt_q  <= '0;
            rx_bcnt_q  <= '0;
            rx_shift_q <= '0;
            rx_ferr_q  <= 1'b0;
            rx_done_q  <= 1'b0;
        end else begin
            rx_sync1_q <= rxd;
            rx_sync2_q <= rx_sync1_q;
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bcnt_q  <= rx_bcnt_d;
            rx_shift_q <= rx_shift_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_done_q  <= rx_done_d;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_perr_q <= 1'b0;
        else        rx_perr_q <= rx_perr_d;
    end
`endif

    // A completed frame is dropped only if the held word is not being consumed this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            rx_frame_err_q  <= 1'b0;
            rx_parity_err_q <= 1'b0;
            rx_overrun_q    <= 1'b0;
        end else begin
            rx_overrun_q <= 1'b0;
            if (rx_done_q) begin
                if (!rx_valid_q || rx_ready) begin
                    rx_data_q       <= rx_shift_q;
                    rx_valid_q      <= 1'b1;
                    rx_frame_err_q  <= rx_ferr_q;
                    rx_parity_err_q <= rx_perr_q;
                end else begin
                    rx_overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q      <= 1'b0;
                rx_frame_err_q  <= 1'b0;
                rx_parity_err_q <= 1'b0;
            end
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_frame_err  = rx_frame_err_q;
    assign rx_parity_err = rx_parity_err_q;
    assign rx_overrun    = rx_overrun_q;

endmodule

// File: tb/tb_uart_trx_param.sv
// Directed + randomised bench for uart_trx_param; line-level frames come from a bit-list model.
module tb_uart_trx_param;

    localparam int DATA_BITS  = 8;
    localparam int BAUD_DIV   = 4;
    localparam int OVERSAMPLE = 16;
    localparam int STOP_BITS  = 1;
    localparam bit PARITY_ODD = 1'b1;
    localparam int BIT_CLKS   = BAUD_DIV * OVERSAMPLE;
`ifdef UART_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_LEN = 1 + DATA_BITS + PAR_BITS + STOP_BITS;

    typedef logic [FRAME_LEN-1:0] frame_t;
    typedef logic [DATA_BITS+1:0] rx_word_t;

    logic                 clk, rst_n;
    logic [DATA_BITS-1:0] tx_data, rx_data;
    logic                 tx_valid, tx_ready, txd, rxd, rx_valid, rx_ready;
    logic                 rx_frame_err, rx_parity_err, rx_overrun;
    logic                 loop_en, rxd_drv;

    int       checks = 0;
    int       errors = 0;
    int       ovr_cycles = 0;
    rx_word_t rxq[$];
    rx_word_t expq[$];

    assign rxd = loop_en ? txd : rxd_drv;

    uart_trx_param #(
        .DATA_BITS (DATA_BITS),
        .BAUD_DIV  (BAUD_DIV),
        .OVERSAMPLE(OVERSAMPLE),
        .STOP_BITS (STOP_BITS),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .txd          (txd),
        .rxd          (rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_parity_err(rx_parity_err),
        .rx_overrun   (rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consumed words and overrun pulse cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rx_valid === 1'b1 && rx_ready === 1'b1)
                rxq.push_back({rx_parity_err, rx_frame_err, rx_data});
            if (rx_overrun === 1'b1) ovr_cycles++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Line levels of one frame, index 0 first on the wire.
    function automatic frame_t build_frame(input logic [DATA_BITS-1:0] d, input logic flip_par,
                                           input logic stop_low);
        frame_t f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < DATA_BITS; i++) f[1+i] = d[i];
        if (PAR_BITS != 0) f[1+DATA_BITS] = (^d) ^ PARITY_ODD ^ flip_par;
        for (int s = 0; s < STOP_BITS; s++) f[1+DATA_BITS+PAR_BITS+s] = ~stop_low;
        return f;
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_tx(input logic [DATA_BITS-1:0] d, input string tag);
        frame_t f;
        int     waited, low_cnt;
        int     match[FRAME_LEN];
        f       = build_frame(d, 1'b0, 1'b0);
        waited  = 0;
        low_cnt = 0;
        while (tx_ready !== 1'b1 && waited < 4 * FRAME_LEN * BIT_CLKS) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check({tag, " ready_before"}, tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        for (int b = 0; b < FRAME_LEN; b++) match[b] = 0;
        for (int k = 0; k < FRAME_LEN * BIT_CLKS + 16; k++) begin
            @(negedge clk);
            if (k < FRAME_LEN * BIT_CLKS && txd === f[k/BIT_CLKS]) match[k/BIT_CLKS]++;
            if (tx_ready === 1'b1) break;
            low_cnt++;
        end
        for (int b = 0; b < FRAME_LEN; b++)
            check($sformatf("%s bit%0d_clks", tag, b), match[b], BIT_CLKS);
        check({tag, " busy_clks"}, low_cnt, FRAME_LEN * BIT_CLKS);
    endtask

    task automatic drive_frame(input frame_t f);
        for (int b = 0; b < FRAME_LEN; b++) begin
            rxd_drv = f[b];
            wait_clks(BIT_CLKS);
        end
    endtask

    task automatic drain(input string tag);
        check({tag, " count"}, rxq.size(), expq.size());
        while (rxq.size() > 0 && expq.size() > 0)
            check({tag, " word"}, rxq.pop_front(), expq.pop_front());
        rxq.delete();
        expq.delete();
    endtask

    initial begin
        logic [DATA_BITS-1:0] r;
        int                   ovr0;

        rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
        loop_en = 1'b0; rxd_drv = 1'b1;
        wait_clks(3);
        check("rst txd", txd, 1);
        check("rst tx_ready", tx_ready, 1);
        check("rst rx_valid", rx_valid, 0);
        check("rst rx_data", rx_data, 0);
        check("rst frame_err", rx_frame_err, 0);
        check("rst parity_err", rx_parity_err, 0);
        check("rst overrun", rx_overrun, 0);
        rst_n = 1'b1;
        wait_clks(5);

        send_tx(8'hA5, "tx_a5");
        r = DATA_BITS'($urandom);
        send_tx(r, "tx_rand");

        // Loopback, consumer always ready.
        rx_ready = 1'b1;
        loop_en  = 1'b1;
        send_tx(8'h3C, "lb_3c");
        send_tx(8'hC3, "lb_c3");
        r = DATA_BITS'($urandom);
        send_tx(r, "lb_rand");
        wait_clks(20);
        expq.push_back({2'b00, 8'h3C});
        expq.push_back({2'b00, 8'hC3});
        expq.push_back({2'b00, r});
        drain("loopback");
        loop_en = 1'b0;

        // Short glitch must be rejected, next frame still received.
        rxd_drv = 1'b0;
        wait_clks(20);
        rxd_drv = 1'b1;
        wait_clks(200);
        check("glitch rx_count", rxq.size(), 0);
        check("glitch rx_valid", rx_valid, 0);
        drive_frame(build_frame(8'h55, 1'b0, 1'b0));
        wait_clks(20);
        expq.push_back({2'b00, 8'h55});
        for (int n = 0; n < 3; n++) begin
            r = DATA_BITS'($urandom);
            drive_frame(build_frame(r, 1'b0, 1'b0));
            expq.push_back({2'b00, r});
        end
        wait_clks(20);
        drain("rx_after_glitch");

        // Low stop bit then a held-low line: one errored frame, nothing more.
        rx_ready = 1'b0;
        ovr0     = ovr_cycles;
        drive_frame(build_frame(8'h55, 1'b0, 1'b1));
        wait_clks(500);
        check("ferr rx_valid", rx_valid, 1);
        check("ferr rx_data", rx_data, 8'h55);
        check("ferr frame_err", rx_frame_err, 1);
        check("ferr parity_err", rx_parity_err, 0);
        rxd_drv = 1'b1;
        wait_clks(300);
        check("ferr no_new_frame", ovr_cycles - ovr0, 0);
        check("ferr data_held", rx_data, 8'h55);
        rx_ready = 1'b1;
        wait_clks(3);
        check("ferr consumed_valid", rx_valid, 0);
        check("ferr consumed_flag", rx_frame_err, 0);
        expq.push_back({2'b01, 8'h55});
        drain("ferr");

        // Second frame arrives while first is still held.
        rx_ready = 1'b0;
        ovr0     = ovr_cycles;
        drive_frame(build_frame(8'h11, 1'b0, 1'b0));
        drive_frame(build_frame(8'h22, 1'b0, 1'b0));
        wait_clks(20);
        check("ovr pulse_cycles", ovr_cycles - ovr0, 1);
        check("ovr rx_valid", rx_valid, 1);
        check("ovr rx_data", rx_data, 8'h11);
        rx_ready = 1'b1;
        wait_clks(3);
        check("ovr consumed_valid", rx_valid, 0);
        check("ovr consumed_ferr", rx_frame_err, 0);
        check("ovr consumed_perr", rx_parity_err, 0);
        expq.push_back({2'b00, 8'h11});
        drain("ovr");

`ifdef UART_PARITY_EN
        send_tx(8'h01, "par_tx01");
        drive_frame(build_frame(8'h01, 1'b1, 1'b0));
        expq.push_back({2'b10, 8'h01});
        r = DATA_BITS'($urandom);
        drive_frame(build_frame(r, 1'b0, 1'b0));
        expq.push_back({2'b00, r});
        wait_clks(20);
        drain("par_rx");
`endif

        // Reset in the middle of a frame releases the line immediately.
        tx_data  = '0;
        tx_valid = 1'b1;
        wait_clks(1);
        tx_valid = 1'b0;
        wait_clks(200);
        check("midrst txd_before", txd, 0);
        check("midrst ready_before", tx_ready, 0);
        rst_n = 1'b0;
        #1;
        check("midrst txd", txd, 1);
        check("midrst tx_ready", tx_ready, 1);
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
